camera_ray_generator: RTL and testbench

//  - Frame-level ray source directly upstream of pipelined_normalization.
//  - On start, walks an IMG_W x IMG_H pixel grid in raster order (x fastest).
//  - Emits one un-normalized, fixed-point camera ray direction per pixel, with a sequential tag.
//  - Backpressure via a valid/ready handshake; output feeds ray_in/start of the normalizer.

---
 rtl/camera_ray_generator.sv | 203 ++++++++++++++++++++
 tb/tb_camera_ray_generator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_ray_generator.sv
// camera_ray_generator
//   Frame-level ray source feeding pipelined_normalization. A start pulse
//   begins a raster walk (x fastest) over an IMG_W x IMG_H grid. For each pixel
//   the block emits one un-normalized fixed-point camera ray direction plus a
//   sequential tag, using a valid/ready handshake.
//
//   Optional feature: define RAYGEN_STATS_EN to add the stall_cycles port.
//
// Ports
//   clk          in   1         clock; all state changes on the rising edge
//   reset        in   1         asynchronous, active-high; clears all state
//   start        in   1         one-cycle pulse; begins a frame when idle
//   ready_in     in   1         downstream accepts a ray this cycle
//   dir_x        out  WIDTH     signed Q-format x direction
//   dir_y        out  WIDTH     signed Q-format y direction
//   dir_z        out  WIDTH     signed Q-format z direction (-FOCAL)
//   tag_out      out  TAG_SIZE  ray sequence tag
//   valid_out    out  1         dir_* / tag_out hold a ray
//   busy         out  1         frame in progress
//   frame_done   out  1         one-cycle pulse after the last ray is accepted
//   stall_cycles out  32        (RAYGEN_STATS_EN only) saturating count of
//                               cycles with valid_out & !ready_in

`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module camera_ray_generator #(
  parameter int WIDTH    = `WIDTH,
  parameter int Q_BITS   = `Q_BITS,
  parameter int TAG_SIZE = `TAG_SIZE,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIX_STEP = 256,
  parameter int FOCAL    = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    ready_in,
  output logic signed [WIDTH-1:0] dir_x,
  output logic signed [WIDTH-1:0] dir_y,
  output logic signed [WIDTH-1:0] dir_z,
  output logic [TAG_SIZE-1:0]     tag_out,
  output logic                    valid_out,
  output logic                    busy,
  output logic                    frame_done
`ifdef RAYGEN_STATS_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int PX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int PY_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic signed [WIDTH-1:0] DIR_Z = WIDTH'(-FOCAL);

  if (Q_BITS < 0 || Q_BITS >= WIDTH || WIDTH > 64 || IMG_W < 2 || IMG_H < 2) begin : g_bad_params
    $error("camera_ray_generator: illegal parameter combination");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PX_W-1:0]     px_p0;
  logic [PY_W-1:0]     py_p0;
  logic [TAG_SIZE-1:0] tag_p0;
  logic                all_loaded_p0;

  logic signed [WIDTH-1:0] dir_x_p1, dir_y_p1, dir_z_p1;
  logic [TAG_SIZE-1:0]     tag_p1;
  logic                    vld_p1;
  logic                    last_p1;
  logic                    frame_done_q;

  logic start_acc, accept, last_acc, load, px_last, py_last;

  // Direction arithmetic is done at 64 bits and then truncated to WIDTH;
  // the parameters are expected to fit, so no saturation is applied.
  function automatic logic signed [WIDTH-1:0] calc_dir_x(input logic [PX_W-1:0] px);
    logic signed [63:0] lin;
    logic signed [63:0] prod;
    lin  = 64'sd2 * $signed(64'(px)) + 64'sd1 - 64'(IMG_W);
    prod = lin * 64'(PIX_STEP);
    return prod[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] calc_dir_y(input logic [PY_W-1:0] py);
    logic signed [63:0] lin;
    logic signed [63:0] prod;
    lin  = 64'(IMG_H) - 64'sd1 - 64'sd2 * $signed(64'(py));
    prod = lin * 64'(PIX_STEP);
    return prod[WIDTH-1:0];
  endfunction

  assign start_acc = (state_q == IDLE) && start;
  assign accept    = vld_p1 && ready_in;
  assign last_acc  = accept && last_p1;
  assign px_last   = (px_p0 == PX_W'(IMG_W - 1));
  assign py_last   = (py_p0 == PY_W'(IMG_H - 1));
  // all_loaded_p0 stops further loads once the final pixel has entered the
  // output register, while that ray may still be waiting for acceptance.
  assign load      = (state_q == RUN) && (!vld_p1 || ready_in) && !all_loaded_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  // ---- stage p0: pixel counters and tag ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_p0         <= '0;
      py_p0         <= '0;
      tag_p0        <= '0;
      all_loaded_p0 <= 1'b0;
    end else if (start_acc) begin
      px_p0         <= '0;
      py_p0         <= '0;
      tag_p0        <= '0;
      all_loaded_p0 <= 1'b0;
    end else if (load) begin
      tag_p0 <= tag_p0 + 1'b1;
      if (px_last) begin
        px_p0 <= '0;
        if (py_last) all_loaded_p0 <= 1'b1;
        else         py_p0 <= py_p0 + 1'b1;
      end else begin
        px_p0 <= px_p0 + 1'b1;
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_x_p1 <= '0;
      dir_y_p1 <= '0;
      dir_z_p1 <= '0;
      tag_p1   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else if (load) begin
      dir_x_p1 <= calc_dir_x(px_p0);
      dir_y_p1 <= calc_dir_y(py_p0);
      dir_z_p1 <= DIR_Z;
      tag_p1   <= tag_p0;
      vld_p1   <= 1'b1;
      last_p1  <= px_last && py_last;
    end else if (accept) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done_q <= 1'b0;
    else       frame_done_q <= last_acc;
  end

`ifdef RAYGEN_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (start_acc) begin
      stall_cycles <= '0;
    end else if (vld_p1 && !ready_in && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  assign dir_x      = dir_x_p1;
  assign dir_y      = dir_y_p1;
  assign dir_z      = dir_z_p1;
  assign tag_out    = tag_p1;
  assign valid_out  = vld_p1;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_camera_ray_generator.sv
// Bench for camera_ray_generator: two instances share all inputs, one with a
// 3-bit tag (a full 8-ray frame has distinct tags) and one with a 2-bit tag
// (tags wrap mid-frame). Expected rays come from a pixel-grid model pushed
// into a queue when a frame is started; a negedge monitor pops on handshake.
module tb_camera_ray_generator;
  localparam int WIDTH = 32, Q_BITS = 16, IMG_W = 4, IMG_H = 2;
  localparam int PIX_STEP = 256, FOCAL = 65536;

  logic clk = 1'b0;
  logic reset, start, ready_in;
  logic signed [WIDTH-1:0] dir_x, dir_y, dir_z, dir_x2, dir_y2, dir_z2;
  logic [2:0] tag_out;
  logic [1:0] tag_out2;
  logic valid_out, busy, frame_done, valid_out2, busy2, frame_done2;
`ifdef RAYGEN_STATS_EN
  logic [31:0] stall_cycles, stall_cycles2;
`endif

  always #5 clk = ~clk;

  camera_ray_generator #(
    .WIDTH(WIDTH), .Q_BITS(Q_BITS), .TAG_SIZE(3), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .PIX_STEP(PIX_STEP), .FOCAL(FOCAL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ready_in(ready_in),
    .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z), .tag_out(tag_out),
    .valid_out(valid_out), .busy(busy), .frame_done(frame_done)
`ifdef RAYGEN_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  camera_ray_generator #(
    .WIDTH(WIDTH), .Q_BITS(Q_BITS), .TAG_SIZE(2), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .PIX_STEP(PIX_STEP), .FOCAL(FOCAL)
  ) dut_t2 (
    .clk(clk), .reset(reset), .start(start), .ready_in(ready_in),
    .dir_x(dir_x2), .dir_y(dir_y2), .dir_z(dir_z2), .tag_out(tag_out2),
    .valid_out(valid_out2), .busy(busy2), .frame_done(frame_done2)
`ifdef RAYGEN_STATS_EN
    , .stall_cycles(stall_cycles2)
`endif
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    int          seq;
  } ray_t;

  ray_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int acc_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  // One frame of expected rays, straight from the pixel-centre formulas.
  task automatic push_frame();
    int seq;
    ray_t r;
    seq = 0;
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        r.x   = (2 * x + 1 - IMG_W) * PIX_STEP;
        r.y   = (IMG_H - 1 - 2 * y) * PIX_STEP;
        r.z   = -FOCAL;
        r.seq = seq;
        seq++;
        exp_q.push_back(r);
      end
    end
  endtask

  // Monitor: outputs are stable at the negedge, and ready_in only changes
  // just after a posedge, so a handshake seen here completes at the next edge.
  logic [31:0] held_x, held_tag;
  bit holding = 0;
  always @(negedge clk) begin
    ray_t r;
    if (reset) begin
      holding = 0;
    end else begin
      if (holding) begin
        chk("hold_valid", 32'(valid_out), 32'd1);
        chk("hold_dir_x", dir_x, held_x);
        chk("hold_tag", 32'(tag_out), held_tag);
      end
      holding = 0;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ray", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("dir_x", dir_x, r.x);
          chk("dir_y", dir_y, r.y);
          chk("dir_z", dir_z, r.z);
          chk("tag", 32'(tag_out), 32'(r.seq % 8));
          chk("tag2_wrap", 32'(tag_out2), 32'(r.seq % 4));
          chk("dut2_dir_x", dir_x2, r.x);
          chk("dut2_valid", 32'(valid_out2), 32'd1);
          acc_count++;
        end
      end else if (valid_out) begin
        holding  = 1;
        held_x   = dir_x;
        held_tag = 32'(tag_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready; 1: 5-cycle stall on tag 2;
  // 2: start pulses during RUN and on the last acceptance; 3: random ready.
  task automatic run_frame(input int mode, input string name);
    int cyc, stalls, exp_stall;
    bit finished;
    cyc = 0; stalls = 0; exp_stall = 0; finished = 0;
    ready_in = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    chk({name, "_lat_valid0"}, 32'(valid_out), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    while (!finished && cyc < 400) begin
      case (mode)
        1: begin
          if (valid_out && tag_out == 3'd2 && stalls < 5) begin
            ready_in = 1'b0;
            stalls++;
            chk({name, "_held_dir_x"}, dir_x, 32'h0000_0100);
          end else begin
            ready_in = 1'b1;
          end
        end
        2: begin
          ready_in = 1'b1;
          if (cyc == 3) start = 1'b1;
          if (valid_out && tag_out == 3'd7) start = 1'b1;
        end
        3: ready_in = 1'($urandom_range(0, 1));
        default: ready_in = 1'b1;
      endcase
      if (valid_out && !ready_in) exp_stall++;
      tick();
      start = 1'b0;
      cyc++;
      if (cyc == 1) chk({name, "_first_valid"}, 32'(valid_out), 32'd1);
      if (frame_done) begin
        finished = 1;
        chk({name, "_done_busy"}, 32'(busy), 32'd0);
        chk({name, "_done_valid"}, 32'(valid_out), 32'd0);
        chk({name, "_done2"}, 32'(frame_done2), 32'd1);
        chk({name, "_all_rays"}, 32'(exp_q.size()), 32'd0);
      end else if (cyc < 8) begin
        chk({name, "_early_done"}, 32'(frame_done), 32'd0);
      end
    end
    if (!finished) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
    end
`ifdef RAYGEN_STATS_EN
    chk({name, "_stall_cycles"}, stall_cycles, 32'(exp_stall));
    if (mode == 1) chk({name, "_stall5"}, stall_cycles, 32'd5);
`endif
    tick();
    chk({name, "_done_pulse"}, 32'(frame_done), 32'd0);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_valid"}, 32'(valid_out), 32'd0);
  endtask

  task automatic reset_mid_frame();
    int cyc;
    cyc = 0;
    acc_count = 0;
    ready_in = 1'b1;
    start = 1'b1;
    push_frame();
    tick();
    start = 1'b0;
    while (acc_count < 4 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("rst_reached_ray3", 32'(acc_count), 32'd4);
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    chk("rst_dir_x", dir_x, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_stays_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ready_in = 1'b0;
    #1;
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    chk("reset_dir_x", dir_x, 32'd0);
    chk("reset_dir_y", dir_y, 32'd0);
    chk("reset_dir_z", dir_z, 32'd0);
    chk("reset_tag", 32'(tag_out), 32'd0);
`ifdef RAYGEN_STATS_EN
    chk("reset_stalls", stall_cycles, 32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;
    ready_in = 1'b1;
    tick();
    tick();
    chk("ready_no_valid", 32'(valid_out), 32'd0);
    chk("ready_no_busy", 32'(busy), 32'd0);

    run_frame(0, "basic");
    run_frame(1, "stall");
    run_frame(2, "start_in_run");
    reset_mid_frame();
    run_frame(0, "after_reset");
    for (int f = 0; f < 3; f++) run_frame(3, "random");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
